game_turn_controller: RTL and testbench

Turn-level game controller for the billiard game. It sits directly downstream of the ball/hole event-conditioning stage and consumes its `hitEnable`, `endOfRoll`, `increasePoint`, `allBallsIn`, `init0` and `flag_hardMode` outputs. It sequences start, aim, roll, respawn, win and lose, and keeps the score and the shot budget. Its `hitEnableStateMachine` output feeds back into that stage to gate the player's hit key.

---
 rtl/game_pkg.sv | 14 +
 rtl/roll_settle_timer.sv | 23 ++
 rtl/game_turn_controller.sv | 100 ++++++++++
 tb/tb_game_turn_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and default parameters for the turn controller.
package game_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AIM     = 3'd1,
    ROLLING = 3'd2,
    RESPAWN = 3'd3,
    WIN     = 3'd4,
    LOSE    = 3'd5
  } game_state_t;
  localparam int SHOTS_EASY_DEF = 15;
  localparam int SHOTS_HARD_DEF = 8;
  localparam int SETTLE_CYC_DEF = 16;
endpackage

// File: rtl/roll_settle_timer.sv
// roll_settle_timer: pulses settled once endOfRoll has held for SETTLE_CYC consecutive enabled cycles.
module roll_settle_timer #(
  parameter int SETTLE_CYC = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic en,
  input  logic endOfRoll,
  output logic settled
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    settled = en && endOfRoll && (cnt_q == CW'(SETTLE_CYC - 1));
    cnt_d   = cnt_q;
    if (clr || settled) cnt_d = '0;
    else if (en) cnt_d = endOfRoll ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/game_turn_controller.sv
// game_turn_controller: turn sequencing FSM with score and shot budget for the billiard game.
module game_turn_controller
  import game_pkg::*;
#(
  parameter int SHOTS_EASY = SHOTS_EASY_DEF,
  parameter int SHOTS_HARD = SHOTS_HARD_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int SCORE_W    = 4,
  parameter int SHOT_W     = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startN,
  input  logic               hitEnable,
  input  logic               endOfRoll,
  input  logic               increasePoint,
  input  logic               allBallsIn,
  input  logic               init0,
  input  logic               flag_hardMode,
  output logic               hitEnableStateMachine,
  output logic               whiteReset,
  output logic [SCORE_W-1:0] score,
  output logic [SHOT_W-1:0]  shotsLeft,
  output logic               gameWon,
  output logic               gameLost,
  output logic [2:0]         state
);
  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SHOT_W-1:0]  shots_q, shots_d;
  logic               scratch_q, scratch_d;
  logic               start_q, start_prev_q, start_p;
  logic               hit, settled, inc, pen, scratch;
  assign start_p = start_prev_q && !start_q;
  assign hit     = (state_q == AIM) && hitEnable;
  assign scratch = scratch_q || init0;
  roll_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk      (clk),
    .resetN   (resetN),
    .clr      (hit),
    .en       (state_q == ROLLING),
    .endOfRoll(endOfRoll),
    .settled  (settled)
  );
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    shots_d   = shots_q;
    case (state_q)
      IDLE:     if (start_p) begin
                  state_d = AIM;
                  shots_d = flag_hardMode ? SHOT_W'(SHOTS_HARD) : SHOT_W'(SHOTS_EASY);
                end
      AIM:      if (hitEnable) begin
                  state_d   = ROLLING;
                  scratch_d = 1'b0;
                  shots_d   = (shots_q == '0) ? shots_q : shots_q - SHOT_W'(1);
                end
      ROLLING: begin
        scratch_d = scratch;
        if (settled)
          state_d = allBallsIn ? WIN : scratch ? RESPAWN : (shots_q == '0) ? LOSE : AIM;
      end
      RESPAWN:  state_d = (shots_q == '0) ? LOSE : AIM;
      default:  if (start_p) state_d = IDLE;
    endcase
  end
  // A pocket and a hard-mode scratch penalty in the same cycle cancel out.
  always_comb begin
    inc     = increasePoint && (state_q inside {AIM, ROLLING, RESPAWN});
    pen     = (state_q == RESPAWN) && flag_hardMode;
    score_d = score_q;
    if (state_q == IDLE && start_p) score_d = '0;
    else if (inc && !pen) score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
    else if (pen && !inc) score_d = (score_q == '0) ? score_q : score_q - SCORE_W'(1);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q      <= IDLE;
      score_q      <= '0;
      shots_q      <= '0;
      scratch_q    <= 1'b0;
      start_q      <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      shots_q      <= shots_d;
      scratch_q    <= scratch_d;
      start_q      <= startN;
      start_prev_q <= start_q;
    end
  assign hitEnableStateMachine = (state_q == AIM);
  assign whiteReset            = (state_q == RESPAWN);
  assign gameWon               = (state_q == WIN);
  assign gameLost              = (state_q == LOSE);
  assign score                 = score_q;
  assign shotsLeft             = shots_q;
  assign state                 = state_q;
endmodule

// File: tb/tb_game_turn_controller.sv
// tb_game_turn_controller: directed scenario bench with immediate-assertion checks.
module tb_game_turn_controller;
  logic clk = 1'b0;
  logic resetN, startN, hitEnable, endOfRoll, increasePoint, allBallsIn, init0, flag_hardMode;
  logic hitEnableStateMachine, whiteReset, gameWon, gameLost;
  logic [3:0] score, shotsLeft;
  logic [2:0] state;
  int tests = 0;
  int fails = 0;
  game_turn_controller dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startN               (startN),
    .hitEnable            (hitEnable),
    .endOfRoll            (endOfRoll),
    .increasePoint        (increasePoint),
    .allBallsIn           (allBallsIn),
    .init0                (init0),
    .flag_hardMode        (flag_hardMode),
    .hitEnableStateMachine(hitEnableStateMachine),
    .whiteReset           (whiteReset),
    .score                (score),
    .shotsLeft            (shotsLeft),
    .gameWon              (gameWon),
    .gameLost             (gameLost),
    .state                (state)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_shots"}, 32'(shotsLeft), 0);
    chk({tag, "_hes"}, 32'(hitEnableStateMachine), 0);
    chk({tag, "_wr"}, 32'(whiteReset), 0);
    chk({tag, "_won"}, 32'(gameWon), 0);
    chk({tag, "_lost"}, 32'(gameLost), 0);
  endtask
  task automatic plain_shot();
    hitEnable = 1'b1;
    step();
    hitEnable = 1'b0;
    endOfRoll = 1'b1;
    repeat (16) step();
    endOfRoll = 1'b0;
  endtask
  initial begin
    resetN = 1'b0; startN = 1'b1; hitEnable = 1'b0; endOfRoll = 1'b0;
    increasePoint = 1'b0; allBallsIn = 1'b0; init0 = 1'b0; flag_hardMode = 1'b0;
    #12;
    chk_reset("reset");
    resetN = 1'b1;
    step(); step();
    // start key held 5 cycles: one AIM entry, two cycles after the press
    startN = 1'b0;
    step();
    chk("start_lat1_state", 32'(state), 0);
    step();
    chk("start_state", 32'(state), 1);
    chk("start_hes", 32'(hitEnableStateMachine), 1);
    chk("start_shots", 32'(shotsLeft), 15);
    chk("start_score", 32'(score), 0);
    repeat (3) step();
    chk("start_hold_state", 32'(state), 1);
    startN = 1'b1;
    // easy roll with one pocket, endOfRoll low for 10 cycles
    hitEnable = 1'b1;
    step();
    hitEnable = 1'b0;
    chk("roll_state", 32'(state), 2);
    chk("roll_shots", 32'(shotsLeft), 14);
    chk("roll_hes", 32'(hitEnableStateMachine), 0);
    increasePoint = 1'b1;
    step();
    increasePoint = 1'b0;
    repeat (9) step();
    endOfRoll = 1'b1;
    repeat (15) step();
    chk("settle15_state", 32'(state), 2);
    step();
    chk("settle16_state", 32'(state), 1);
    chk("roll_score", 32'(score), 1);
    endOfRoll = 1'b0;
    // win takes priority over scratch
    hitEnable = 1'b1;
    step();
    hitEnable = 1'b0;
    init0 = 1'b1;
    step();
    init0 = 1'b0;
    endOfRoll = 1'b1;
    allBallsIn = 1'b1;
    repeat (16) step();
    chk("win_state", 32'(state), 4);
    chk("win_won", 32'(gameWon), 1);
    endOfRoll = 1'b0;
    allBallsIn = 1'b0;
    hitEnable = 1'b1;
    step(); step();
    hitEnable = 1'b0;
    chk("win_hit_ignored", 32'(state), 4);
    startN = 1'b0;
    step(); step();
    chk("win_restart_state", 32'(state), 0);
    chk("win_restart_won", 32'(gameWon), 0);
    startN = 1'b1;
    step();
    // hard mode scratch with penalty
    flag_hardMode = 1'b1;
    startN = 1'b0;
    step(); step();
    startN = 1'b1;
    chk("hard_shots", 32'(shotsLeft), 8);
    increasePoint = 1'b1;
    step(); step();
    increasePoint = 1'b0;
    chk("hard_score2", 32'(score), 2);
    hitEnable = 1'b1;
    step();
    hitEnable = 1'b0;
    init0 = 1'b1;
    step();
    init0 = 1'b0;
    endOfRoll = 1'b1;
    repeat (16) step();
    endOfRoll = 1'b0;
    chk("respawn_state", 32'(state), 3);
    chk("respawn_wr", 32'(whiteReset), 1);
    step();
    chk("respawn_exit_state", 32'(state), 1);
    chk("respawn_score", 32'(score), 1);
    chk("respawn_wr_low", 32'(whiteReset), 0);
    // burn shots down to the last one, then lose
    repeat (6) plain_shot();
    chk("last_shot_state", 32'(state), 1);
    chk("last_shot_shots", 32'(shotsLeft), 1);
    hitEnable = 1'b1;
    step();
    hitEnable = 1'b0;
    chk("zero_shots", 32'(shotsLeft), 0);
    endOfRoll = 1'b1;
    repeat (15) step();
    endOfRoll = 1'b0;
    step();
    chk("glitch_state", 32'(state), 2);
    endOfRoll = 1'b1;
    repeat (15) step();
    chk("glitch_restart_state", 32'(state), 2);
    step();
    chk("lose_state", 32'(state), 5);
    chk("lose_lost", 32'(gameLost), 1);
    endOfRoll = 1'b0;
    // asynchronous reset mid-roll
    startN = 1'b0;
    step(); step();
    startN = 1'b1;
    step();
    chk("lose_restart_state", 32'(state), 0);
    startN = 1'b0;
    step(); step();
    startN = 1'b1;
    increasePoint = 1'b1;
    repeat (3) step();
    increasePoint = 1'b0;
    hitEnable = 1'b1;
    step();
    hitEnable = 1'b0;
    chk("pre_reset_state", 32'(state), 2);
    chk("pre_reset_score", 32'(score), 3);
    #2;
    resetN = 1'b0;
    #1;
    chk_reset("async_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
